// File: rtl/bcd_time_counter_pkg.sv
// Shared types, digit limits and set-value validity check for the timekeeper
// and its neighbours (alarm comparator reuses hhmm_valid).
package bcd_time_counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX      = 4'd5;
    localparam bcd_t MIN_TENS_MAX      = 4'd5;
    localparam bcd_t HR_TENS_MAX       = 4'd2;
    localparam bcd_t HR_ONES_MAX_AT_20 = 4'd3;
    localparam bcd_t ONES_MAX          = 4'd9;

    // A set HH:MM is legal only inside 00:00..23:59.
    function automatic logic hhmm_valid(input bcd_t h1, input bcd_t h0,
                                        input bcd_t m1, input bcd_t m0);
        logic ok;
        ok = (h1 <= HR_TENS_MAX) && (h0 <= ONES_MAX) &&
             (m1 <= MIN_TENS_MAX) && (m0 <= ONES_MAX);
        if ((h1 == HR_TENS_MAX) && (h0 > HR_ONES_MAX_AT_20)) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_time_counter_digit.sv
// One BCD digit with synchronous clear/load, wrap at a runtime maximum and a
// combinational carry so digits can be chained within a single tick.
module bcd_digit_counter
    import bcd_time_counter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic load,
    input  bcd_t load_val,
    input  logic inc,
    input  bcd_t max,
    output bcd_t digit,
    output logic carry
);

    bcd_t digit_r;
    logic at_max_s;

    // >= rather than == so an out-of-range value still wraps back to zero.
    assign at_max_s = (digit_r >= max);
    assign carry    = inc && at_max_s;
    assign digit    = digit_r;

    // Digit register: clear beats load beats increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_r <= 4'd0;
        end else if (clear) begin
            digit_r <= 4'd0;
        end else if (load) begin
            digit_r <= load_val;
        end else if (inc) begin
            digit_r <= at_max_s ? 4'd0 : (digit_r + 4'd1);
        end else begin
            digit_r <= digit_r;
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour HH:MM:SS timekeeper: one-second prescaler, six chained BCD digits,
// set-value loading with validity check, and registered event pulses.
module bcd_time_counter
    import bcd_time_counter_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int PRESC_W = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic       load,
    input  logic [3:0] set_h1,
    input  logic [3:0] set_h0,
    input  logic [3:0] set_m1,
    input  logic [3:0] set_m0,
    output logic [3:0] h1,
    output logic [3:0] h0,
    output logic [3:0] m1,
    output logic [3:0] m0,
    output logic [3:0] s1,
    output logic [3:0] s0,
    output logic       sec_pulse,
    output logic       min_pulse,
    output logic       load_err,
    output logic       colon
);

    localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(CLK_HZ - 1);
    localparam logic [PRESC_W-1:0] PRESC_HALF = PRESC_W'(CLK_HZ / 2);

    logic [PRESC_W-1:0] presc_r;
    logic [PRESC_W-1:0] presc_nxt_s;
    logic               tick_s;
    logic               valid_s;
    logic               load_ok_s;
    logic               load_bad_s;
    logic               inc_s;
    logic [4:0]         carry_s;
    logic               hr_carry_unused_s;
    bcd_t               h0_max_s;
    logic               sec_pulse_r;
    logic               min_pulse_r;
    logic               load_err_r;
    logic               colon_r;

    assign tick_s     = (presc_r == PRESC_TERM);
    assign valid_s    = hhmm_valid(set_h1, set_h0, set_m1, set_m0);
    assign load_ok_s  = load && valid_s;
    assign load_bad_s = load && !valid_s;
    // Any load (even a rejected one) swallows the tick of its cycle.
    assign inc_s      = tick_s && !load && !hold;

    // Prescaler next value: valid load restarts, load/hold freeze, tick wraps.
    always_comb begin
        presc_nxt_s = presc_r;
        if (load_ok_s) begin
            presc_nxt_s = {PRESC_W{1'b0}};
        end else if (load || hold) begin
            presc_nxt_s = presc_r;
        end else if (tick_s) begin
            presc_nxt_s = {PRESC_W{1'b0}};
        end else begin
            presc_nxt_s = presc_r + PRESC_W'(1);
        end
    end

    // Hours-ones limit drops to 3 once the tens digit reaches 2.
    always_comb begin
        h0_max_s = ONES_MAX;
        if (h1 == HR_TENS_MAX) begin
            h0_max_s = HR_ONES_MAX_AT_20;
        end else begin
            h0_max_s = ONES_MAX;
        end
    end

    bcd_digit_counter u_s0 (
        .clk(clk), .reset(reset), .clear(load_ok_s), .load(1'b0), .load_val(4'd0),
        .inc(inc_s), .max(ONES_MAX), .digit(s0), .carry(carry_s[0])
    );
    bcd_digit_counter u_s1 (
        .clk(clk), .reset(reset), .clear(load_ok_s), .load(1'b0), .load_val(4'd0),
        .inc(carry_s[0]), .max(SEC_TENS_MAX), .digit(s1), .carry(carry_s[1])
    );
    bcd_digit_counter u_m0 (
        .clk(clk), .reset(reset), .clear(1'b0), .load(load_ok_s), .load_val(set_m0),
        .inc(carry_s[1]), .max(ONES_MAX), .digit(m0), .carry(carry_s[2])
    );
    bcd_digit_counter u_m1 (
        .clk(clk), .reset(reset), .clear(1'b0), .load(load_ok_s), .load_val(set_m1),
        .inc(carry_s[2]), .max(MIN_TENS_MAX), .digit(m1), .carry(carry_s[3])
    );
    bcd_digit_counter u_h0 (
        .clk(clk), .reset(reset), .clear(1'b0), .load(load_ok_s), .load_val(set_h0),
        .inc(carry_s[3]), .max(h0_max_s), .digit(h0), .carry(carry_s[4])
    );
    // Day wrap needs no action beyond both hour digits returning to zero.
    bcd_digit_counter u_h1 (
        .clk(clk), .reset(reset), .clear(1'b0), .load(load_ok_s), .load_val(set_h1),
        .inc(carry_s[4]), .max(HR_TENS_MAX), .digit(h1), .carry(hr_carry_unused_s)
    );

    // Prescaler and registered event/colon outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_r     <= {PRESC_W{1'b0}};
            sec_pulse_r <= 1'b0;
            min_pulse_r <= 1'b0;
            load_err_r  <= 1'b0;
            colon_r     <= 1'b1;
        end else begin
            presc_r     <= presc_nxt_s;
            sec_pulse_r <= inc_s;
            min_pulse_r <= carry_s[1];
            load_err_r  <= load_bad_s;
            colon_r     <= (presc_nxt_s < PRESC_HALF);
        end
    end

    assign sec_pulse = sec_pulse_r;
    assign min_pulse = min_pulse_r;
    assign load_err  = load_err_r;
    assign colon     = colon_r;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench for bcd_time_counter at CLK_HZ=4: stimulus queues expected
// {time, sec, min, err, colon} records; the monitor pops one per event/snapshot.
module tb_bcd_time_counter;

    localparam int CLK_HZ  = 4;
    localparam int PRESC_W = 3;

    logic       clk;
    logic       reset;
    logic       hold;
    logic       load;
    logic [3:0] set_h1, set_h0, set_m1, set_m0;
    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic       sec_pulse, min_pulse, load_err, colon;

    logic        snap_req   = 1'b0;
    logic        final_chk  = 1'b0;
    logic        final_done = 1'b0;
    logic [27:0] exp_q[$];
    int          checks     = 0;
    int          errors     = 0;

    bcd_time_counter #(.CLK_HZ(CLK_HZ), .PRESC_W(PRESC_W)) dut (
        .clk(clk), .reset(reset), .hold(hold), .load(load),
        .set_h1(set_h1), .set_h0(set_h0), .set_m1(set_m1), .set_m0(set_m0),
        .h1(h1), .h0(h0), .m1(m1), .m0(m0), .s1(s1), .s0(s0),
        .sec_pulse(sec_pulse), .min_pulse(min_pulse), .load_err(load_err), .colon(colon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] mk(input logic [23:0] t, input logic sp,
                                       input logic mp, input logic le, input logic co);
        return {t, sp, mp, le, co};
    endfunction

    // Monitor: one pop per DUT event or requested snapshot, sampled mid-cycle.
    always @(negedge clk) begin : mon
        logic [27:0] got;
        logic [27:0] expv;
        got = {h1, h0, m1, m0, s1, s0, sec_pulse, min_pulse, load_err, colon};
        if (sec_pulse || min_pulse || load_err || snap_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got=%h (no record queued)", got);
            end else begin
                expv = exp_q.pop_front();
                if (got !== expv) begin
                    errors++;
                    $display("FAIL record got=%h exp=%h (time,sec,min,err,colon)", got, expv);
                end
            end
        end
        if (final_chk && !final_done) begin
            final_done = 1'b1;
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL queue_drain got=%0d pending exp=0", exp_q.size());
            end
        end
    end

    task automatic clk_n(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Check the state produced by the next clock edge.
    task automatic expect_at(input logic [27:0] r);
        exp_q.push_back(r);
        snap_req = 1'b1;
        clk_n(1);
        snap_req = 1'b0;
    endtask

    task automatic tick_now(input logic [23:0] t, input logic mp);
        exp_q.push_back(mk(t, 1'b1, mp, 1'b0, 1'b1));
        clk_n(1);
    endtask

    task automatic run_tick(input logic [23:0] t, input logic mp);
        clk_n(3);
        tick_now(t, mp);
    endtask

    task automatic do_load(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
        set_h1 = a; set_h0 = b; set_m1 = c; set_m0 = d;
        load = 1'b1;
        expect_at(mk({a, b, c, d, 8'h00}, 1'b0, 1'b0, 1'b0, 1'b1));
        load = 1'b0;
    endtask

    // Rejected load from prescaler 0: err pulse, then normal tick 4 edges later.
    task automatic bad_load(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d,
                            input logic [23:0] now_t, input logic [23:0] next_t);
        set_h1 = a; set_h0 = b; set_m1 = c; set_m0 = d;
        load = 1'b1;
        exp_q.push_back(mk(now_t, 1'b0, 1'b0, 1'b1, 1'b1));
        clk_n(1);
        load = 1'b0;
        clk_n(2);
        expect_at(mk(now_t, 1'b0, 1'b0, 1'b0, 1'b0));
        tick_now(next_t, 1'b0);
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0; load = 1'b0;
        set_h1 = 4'd0; set_h0 = 4'd0; set_m1 = 4'd0; set_m0 = 4'd0;
        clk_n(2);
        expect_at(mk(24'h000000, 1'b0, 1'b0, 1'b0, 1'b1));

        // Reach 12:34:56, then reset asynchronously between edges.
        reset = 1'b0;
        do_load(4'd1, 4'd2, 4'd3, 4'd4);
        for (int i = 1; i <= 56; i++) run_tick({16'h1234, 4'(i / 10), 4'(i % 10)}, 1'b0);
        clk_n(1);
        @(posedge clk);
        #1;
        exp_q.push_back(mk(24'h000000, 1'b0, 1'b0, 1'b0, 1'b1));
        snap_req = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        #1;
        snap_req = 1'b0;
        clk_n(1);
        reset = 1'b0;
        clk_n(2);
        expect_at(mk(24'h000000, 1'b0, 1'b0, 1'b0, 1'b0));
        tick_now(24'h000001, 1'b0);

        // 09:59:59 -> 10:00:00
        do_load(4'd0, 4'd9, 4'd5, 4'd9);
        for (int i = 1; i <= 59; i++) run_tick({16'h0959, 4'(i / 10), 4'(i % 10)}, 1'b0);
        run_tick(24'h100000, 1'b1);

        // 23:59:59 -> 00:00:00
        do_load(4'd2, 4'd3, 4'd5, 4'd9);
        for (int i = 1; i <= 59; i++) run_tick({16'h2359, 4'(i / 10), 4'(i % 10)}, 1'b0);
        run_tick(24'h000000, 1'b1);

        // Rejected set values
        bad_load(4'd2, 4'd4, 4'd0, 4'd0, 24'h000000, 24'h000001);
        bad_load(4'd1, 4'd2, 4'd6, 4'd0, 24'h000001, 24'h000002);

        // Load landing on the terminal prescaler cycle
        clk_n(3);
        do_load(4'd1, 4'd5, 4'd4, 4'd5);
        clk_n(2);
        expect_at(mk(24'h154500, 1'b0, 1'b0, 1'b0, 1'b0));
        tick_now(24'h154501, 1'b0);

        // Hold for 10 edges at prescaler 2
        clk_n(2);
        hold = 1'b1;
        expect_at(mk(24'h154501, 1'b0, 1'b0, 1'b0, 1'b0));
        clk_n(8);
        expect_at(mk(24'h154501, 1'b0, 1'b0, 1'b0, 1'b0));
        hold = 1'b0;
        expect_at(mk(24'h154501, 1'b0, 1'b0, 1'b0, 1'b0));
        tick_now(24'h154502, 1'b0);

        // Multi-cycle load during hold
        hold = 1'b1;
        set_h1 = 4'd2; set_h0 = 4'd0; set_m1 = 4'd0; set_m0 = 4'd7;
        load = 1'b1;
        expect_at(mk(24'h200700, 1'b0, 1'b0, 1'b0, 1'b1));
        expect_at(mk(24'h200700, 1'b0, 1'b0, 1'b0, 1'b1));
        expect_at(mk(24'h200700, 1'b0, 1'b0, 1'b0, 1'b1));
        load = 1'b0;
        hold = 1'b0;
        clk_n(2);
        expect_at(mk(24'h200700, 1'b0, 1'b0, 1'b0, 1'b0));
        tick_now(24'h200701, 1'b0);

        hold = 1'b1;
        clk_n(3);
        final_chk = 1'b1;
        clk_n(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
